// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read-side controller of the 8-deep async FIFO (rclk domain); owns the read pointers,
// derives empty and feeds a 1-entry valid/ready output slice. Optional macro: FIFO_RD_LEVEL_EN.
`default_nettype none

module fifo_rd_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDR_W:0]   rq2_wptr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd_enable_fifo,
  output logic [ADDR_W:0]   b_rd_ptr,
  output logic [ADDR_W:0]   g_rd_ptr,
  output logic              rempty,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADDR_W:0]   rd_level
`endif
);

  logic [ADDR_W:0]   b_rd_ptr_q, b_rd_ptr_d;
  logic [ADDR_W:0]   g_rd_ptr_q, g_rd_ptr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              w_empty;
  logic              w_pop;

  // Full-width compare: the MSB separates a lapped pointer from an equal one.
  assign w_empty = (g_rd_ptr_q == rq2_wptr);
  assign w_pop   = rrst_n & ~w_empty & (~out_valid_q | out_ready);

  always_comb begin
    b_rd_ptr_d  = b_rd_ptr_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    if (w_pop) begin
      b_rd_ptr_d  = b_rd_ptr_q + 1'b1;
      out_data_d  = rd_data;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    g_rd_ptr_d = b_rd_ptr_d ^ (b_rd_ptr_d >> 1);
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      b_rd_ptr_q  <= '0;
      g_rd_ptr_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      b_rd_ptr_q  <= b_rd_ptr_d;
      g_rd_ptr_q  <= g_rd_ptr_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ADDR_W:0] w_wptr_bin;
  logic [ADDR_W:0] rd_level_q, rd_level_d;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    w_wptr_bin = '0;
    for (int i = 0; i <= ADDR_W; i++) begin
      w_wptr_bin[i] = ^(rq2_wptr >> i);
    end
    rd_level_d = w_wptr_bin - b_rd_ptr_d;
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      rd_level_q <= '0;
    end else begin
      rd_level_q <= rd_level_d;
    end
  end

  assign rd_level = rd_level_q;
`endif

  assign rd_enable_fifo = w_pop;
  assign rempty         = w_empty;
  assign b_rd_ptr       = b_rd_ptr_q;
  assign g_rd_ptr       = g_rd_ptr_q;
  assign out_data       = out_data_q;
  assign out_valid      = out_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: randomized bench for fifo_rd_ctrl against a word-count/queue model of the FIFO.
`default_nettype none

module tb_fifo_rd_ctrl;

  logic       clk = 1'b0;
  logic       rrst_n;
  logic [3:0] rq2_wptr;
  logic [7:0] rd_data;
  logic       rd_enable_fifo;
  logic [3:0] b_rd_ptr;
  logic [3:0] g_rd_ptr;
  logic       rempty;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
`ifdef FIFO_RD_LEVEL_EN
  logic [3:0] rd_level;
`endif

  fifo_rd_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
    .rclk(clk), .rrst_n(rrst_n), .rq2_wptr(rq2_wptr), .rd_data(rd_data),
    .rd_enable_fifo(rd_enable_fifo), .b_rd_ptr(b_rd_ptr), .g_rd_ptr(g_rd_ptr),
    .rempty(rempty), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
`ifdef FIFO_RD_LEVEL_EN
    , .rd_level(rd_level)
`endif
  );

  always #5 clk = ~clk;

  // FWFT memory: drives the addressed word only while popped.
  logic [7:0] mem [8];
  assign rd_data = rd_enable_fifo ? mem[b_rd_ptr[2:0]] : 8'h00;

  int total = 0;
  int bad   = 0;

  // Model: absolute write/read word counts, every written word by index, and the output slice.
  int         wcnt = 0;
  int         rcnt = 0;
  logic [7:0] words [4096];
  bit         exp_v = 1'b0;
  logic [7:0] exp_d = 8'h00;
  int         exp_lvl = 0;
  bit         chk_en = 1'b0;

  function automatic logic [3:0] to_gray(input int b);
    logic [3:0] v;
    v = b[3:0];
    return v ^ (v >> 1);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit model_empty();
    return ((wcnt - rcnt) & 15) == 0;
  endfunction

  always @(posedge clk) begin
    if (!rrst_n) begin
      rcnt    = 0;
      exp_v   = 1'b0;
      exp_d   = 8'h00;
      exp_lvl = 0;
      chk_en  = 1'b1;
    end else begin
      if (!model_empty() && (!exp_v || out_ready)) begin
        exp_d = words[rcnt & 4095];
        exp_v = 1'b1;
        rcnt++;
      end else if (exp_v && out_ready) begin
        exp_v = 1'b0;
      end
      exp_lvl = (wcnt - rcnt) & 15;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("rempty", rempty, model_empty());
      chk("rd_enable_fifo", rd_enable_fifo, rrst_n && !model_empty() && (!exp_v || out_ready));
      chk("b_rd_ptr", b_rd_ptr, rcnt & 15);
      chk("g_rd_ptr", g_rd_ptr, to_gray(rcnt));
      chk("out_valid", out_valid, exp_v);
      chk("out_data", out_data, exp_d);
`ifdef FIFO_RD_LEVEL_EN
      chk("rd_level", rd_level, exp_lvl);
`endif
    end
  end

  task automatic cyc(input bit rdy, input bit rn);
    @(posedge clk);
    #1;
    rrst_n    = rn;
    out_ready = rdy;
    if (!rn) begin
      wcnt     = 0;
      rq2_wptr = 4'd0;
    end
  endtask

  // Writes one word if the FIFO has room; the pointer is presented already synchronised.
  task automatic push(input logic [7:0] val);
    if (rrst_n && (wcnt - rcnt) < 8) begin
      mem[wcnt & 7]       = val;
      words[wcnt & 4095]  = val;
      wcnt++;
      rq2_wptr = to_gray(wcnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rrst_n = 1'b0; out_ready = 1'b0; rq2_wptr = 4'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    cyc(0, 0);
    cyc(0, 0);
    chk("t1_rempty", rempty, 1);
    chk("t1_out_valid", out_valid, 0);
    chk("t1_b_rd_ptr", b_rd_ptr, 0);
    chk("t1_rd_en", rd_enable_fifo, 0);

    cyc(1, 1);
    push(8'hA5);
    cyc(1, 1);
    chk("t2_out_data", out_data, 8'hA5);
    chk("t2_out_valid", out_valid, 1);
    chk("t2_b_rd_ptr", b_rd_ptr, 1);
    chk("t2_g_rd_ptr", g_rd_ptr, 4'b0001);
    chk("t2_rempty", rempty, 1);
    cyc(1, 1);

    cyc(0, 0);
    cyc(1, 1);
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    for (int k = 0; k < 8; k++) begin
      cyc(1, 1);
      chk("t3_beat_valid", out_valid, 1);
      chk("t3_beat_data", out_data, 8'h10 + 8'(k));
    end
    chk("t3_b_rd_ptr", b_rd_ptr, 8);
    chk("t3_g_rd_ptr", g_rd_ptr, 4'b1100);
    chk("t3_rempty", rempty, 1);

    cyc(1, 1);
    cyc(0, 1);
    push(8'h31); push(8'h32); push(8'h33);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1);
      chk("t4_stall_data", out_data, 8'h31);
      chk("t4_stall_ptr", b_rd_ptr, 9);
    end
    cyc(1, 1);
    cyc(1, 1);
    chk("t4_second", out_data, 8'h32);
    cyc(1, 1);
    chk("t4_third", out_data, 8'h33);
    chk("t4_third_valid", out_valid, 1);
    cyc(1, 1);
    chk("t4_drained", out_valid, 0);

    for (int i = 0; i < 21; i++) begin
      cyc(1, 1);
      push(8'h40 + 8'(i));
    end
    repeat (3) cyc(1, 1);
    chk("t5_b_wrap", b_rd_ptr, 0);
    chk("t5_g_wrap", g_rd_ptr, 0);

    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 2) != 0), ($urandom_range(0, 99) != 0));
      for (int n = $urandom_range(0, 2); n > 0; n--) push(8'($urandom));
    end

    repeat (12) cyc(1, 1);
    cyc(0, 1);
    push(8'h66);
    cyc(0, 1);
    cyc(0, 1);
    chk("t6_held_valid", out_valid, 1);
    cyc(0, 0);
    cyc(0, 1);
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ptr", b_rd_ptr, 0);

`ifdef FIFO_RD_LEVEL_EN
    cyc(0, 0);
    cyc(0, 1);
    for (int i = 0; i < 5; i++) push(8'h70 + 8'(i));
    cyc(1, 1);
    cyc(0, 1);
    chk("level_5w_2p", rd_level, 3);
`endif

    repeat (4) cyc(1, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
